// File: rtl/alu_share_arbiter.sv
// Purpose: round-robin share of one combinational ALU between two requesters, result in one output register.
// Latency: an operation accepted in cycle T has its registered result valid in cycle T+1.
// Backpressure: out_valid/out_ready; both req readys drop while a held result is not taken, slot refills same cycle.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_BITS    = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // requester 0
  input  logic                  req0_valid,
  input  logic [OP_BITS-1:0]    req0_op,
  input  logic [DATA_WIDTH-1:0] req0_data1,
  input  logic [DATA_WIDTH-1:0] req0_data2,
  output logic                  req0_ready,
  // requester 1
  input  logic                  req1_valid,
  input  logic [OP_BITS-1:0]    req1_op,
  input  logic [DATA_WIDTH-1:0] req1_data1,
  input  logic [DATA_WIDTH-1:0] req1_data2,
  output logic                  req1_ready,
  // result stage
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_compare,
  output logic                  out_id,
  output logic                  out_err
);

  localparam logic [OP_BITS-1:0] OP_ADD   = OP_BITS'(0);
  localparam logic [OP_BITS-1:0] OP_SUB   = OP_BITS'(1);
  localparam logic [OP_BITS-1:0] OP_LNOT  = OP_BITS'(2);
  localparam logic [OP_BITS-1:0] OP_AND   = OP_BITS'(3);
  localparam logic [OP_BITS-1:0] OP_OR    = OP_BITS'(4);
  localparam logic [OP_BITS-1:0] OP_NAND  = OP_BITS'(5);
  localparam logic [OP_BITS-1:0] OP_NOR   = OP_BITS'(6);
  localparam logic [OP_BITS-1:0] OP_PASS1 = OP_BITS'(7);
  localparam logic [OP_BITS-1:0] OP_PASS2 = OP_BITS'(8);
  localparam logic [OP_BITS-1:0] OP_XOR   = OP_BITS'(12);

  // Requester that won the most recent transfer; reset value 1 hands the first tie to requester 0.
  logic                  last_grant;

  logic                  can_accept;
  logic                  grant0;
  logic                  grant1;
  logic                  xfer;
  logic                  xfer_id;

  logic [OP_BITS-1:0]    sel_op;
  logic [DATA_WIDTH-1:0] sel_d1;
  logic [DATA_WIDTH-1:0] sel_d2;

  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_err;
  logic                  alu_compare;

  // The output slot can take a new result when empty or when its current result leaves this cycle.
  assign can_accept = !out_valid || out_ready;

  // Round-robin grant: a lone valid requester wins; on a tie the one not served last time wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = last_grant;
      grant1 = !last_grant;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign req0_ready = can_accept && grant0;
  assign req1_ready = can_accept && grant1;

  // A handshake always coincides with the granted requester's ready, so ready alone marks the transfer.
  assign xfer    = req0_ready || req1_ready;
  assign xfer_id = req1_ready;

  // Steer the granted requester's operation into the shared datapath.
  always_comb begin
    sel_op = req0_op;
    sel_d1 = req0_data1;
    sel_d2 = req0_data2;
    if (grant1) begin
      sel_op = req1_op;
      sel_d1 = req1_data1;
      sel_d2 = req1_data2;
    end
  end

  // Shared ALU; unsupported opcodes produce zero and raise err, compare is computed regardless.
  always_comb begin
    alu_result  = '0;
    alu_err     = 1'b0;
    alu_compare = (sel_d1 == sel_d2);
    case (sel_op)
      OP_ADD:   alu_result = sel_d1 + sel_d2;
      OP_SUB:   alu_result = sel_d1 - sel_d2;
      OP_LNOT:  alu_result = {{(DATA_WIDTH-1){1'b0}}, (sel_d1 == '0)};
      OP_AND:   alu_result = sel_d1 & sel_d2;
      OP_OR:    alu_result = sel_d1 | sel_d2;
      OP_NAND:  alu_result = ~(sel_d1 & sel_d2);
      OP_NOR:   alu_result = ~(sel_d1 | sel_d2);
      OP_PASS1: alu_result = sel_d1;
      OP_PASS2: alu_result = sel_d2;
      OP_XOR:   alu_result = sel_d1 ^ sel_d2;
      default: begin
        alu_result = '0;
        alu_err    = 1'b1;
      end
    endcase
  end

  // Output register: load on transfer, empty when the consumer takes the result and nothing replaces it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_compare <= 1'b0;
      out_id      <= 1'b0;
      out_err     <= 1'b0;
    end else if (xfer) begin
      out_valid   <= 1'b1;
      out_result  <= alu_result;
      out_compare <= alu_compare;
      out_id      <= xfer_id;
      out_err     <= alu_err;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

  // Grant pointer moves only on an actual transfer so an unserved request keeps its claim.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (xfer) begin
      last_grant <= xfer_id;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Purpose: scoreboard bench for alu_share_arbiter with directed cases and randomized traffic.
// Latency: expected results are queued at the accepting edge and checked while presented one cycle later.
// Backpressure: random and directed out_ready stalls; held outputs are compared every cycle they are valid.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_data1, req0_data2, req1_data1, req1_data2;
  logic        req0_ready, req1_ready;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_compare, out_id, out_err;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_WIDTH(32), .OP_BITS(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_op    (req0_op),
    .req0_data1 (req0_data1),
    .req0_data2 (req0_data2),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_op    (req1_op),
    .req1_data1 (req1_data1),
    .req1_data2 (req1_data2),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_compare(out_compare),
    .out_id     (out_id),
    .out_err    (out_err)
  );

  typedef struct packed {
    logic [31:0] result;
    logic        compare;
    logic        err;
    logic        id;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  // reference state: is the result slot occupied, who was served last
  logic model_full = 1'b0;
  logic model_last = 1'b1;
  logic xfer0 = 1'b0;
  logic xfer1 = 1'b0;
  logic exp_can, win0, win1;

  function automatic exp_t ref_alu(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic id);
    exp_t e;
    e.compare = (a == b);
    e.err     = 1'b0;
    e.id      = id;
    e.result  = 32'd0;
    case (op)
      4'd0:  e.result = a + b;
      4'd1:  e.result = a - b;
      4'd2:  e.result = (a == 32'd0) ? 32'd1 : 32'd0;
      4'd3:  e.result = a & b;
      4'd4:  e.result = a | b;
      4'd5:  e.result = ~(a & b);
      4'd6:  e.result = ~(a | b);
      4'd7:  e.result = a;
      4'd8:  e.result = b;
      4'd12: e.result = a ^ b;
      default: begin
        e.result = 32'd0;
        e.err    = 1'b1;
      end
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: a lone valid requester wins, a tie goes to whoever was not served last.
  always @(negedge clk) begin
    if (!reset_n) begin
      xfer0 = 1'b0;
      xfer1 = 1'b0;
    end else begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, model_full});
      exp_can = !model_full || out_ready;
      if (req0_valid && req1_valid) begin
        win0 = (model_last == 1'b1);
        win1 = (model_last == 1'b0);
      end else begin
        win0 = req0_valid;
        win1 = req1_valid;
      end
      if (req0_valid) chk("req0_ready", {31'd0, req0_ready}, {31'd0, exp_can && win0});
      if (req1_valid) chk("req1_ready", {31'd0, req1_ready}, {31'd0, exp_can && win1});
      xfer0 = req0_valid && req0_ready;
      xfer1 = req1_valid && req1_ready;
      if (xfer0) begin
        sb_q.push_back(ref_alu(req0_op, req0_data1, req0_data2, 1'b0));
        model_last = 1'b0;
      end
      if (xfer1) begin
        sb_q.push_back(ref_alu(req1_op, req1_data1, req1_data2, 1'b1));
        model_last = 1'b1;
      end
      if (xfer0 || xfer1) model_full = 1'b1;
      else if (out_ready) model_full = 1'b0;
    end
  end

  // Monitor: every cycle a result is presented it must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got result 0x%08h, expected no output", out_result);
      end else begin
        mon_e = sb_q[0];
        chk("out_result",  out_result,            mon_e.result);
        chk("out_compare", {31'd0, out_compare},  {31'd0, mon_e.compare});
        chk("out_err",     {31'd0, out_err},      {31'd0, mon_e.err});
        chk("out_id",      {31'd0, out_id},       {31'd0, mon_e.id});
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin
      req0_valid = v; req0_op = op; req0_data1 = a; req0_data2 = b;
    end else begin
      req1_valid = v; req1_op = op; req1_data1 = a; req1_data2 = b;
    end
  endtask

  task automatic wait_xfer(input int n);
    bit done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      step();
      done = (n == 0) ? xfer0 : xfer1;
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL timeout_req%0d: got no handshake in 20 cycles, expected one", n);
    end
  endtask

  // Called just after a rising edge; reset lands between edges to exercise the asynchronous clear.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_out_valid",   {31'd0, out_valid},   32'd0);
    chk("rst_out_result",  out_result,           32'd0);
    chk("rst_out_compare", {31'd0, out_compare}, 32'd0);
    chk("rst_out_id",      {31'd0, out_id},      32'd0);
    chk("rst_out_err",     {31'd0, out_err},     32'd0);
    sb_q.delete();
    model_full = 1'b0;
    model_last = 1'b1;
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Both requesters valid right after reset: requester 0 must win the first tie.
  task automatic tie_check();
    set_req(0, 1'b1, 4'd3, 32'hF0F0_1234, 32'h0FF0_FFFF);
    set_req(1, 1'b1, 4'd4, 32'h0000_00A0, 32'h0000_000B);
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("first_tie_ready0", {31'd0, req0_ready}, 32'd1);
    chk("first_tie_ready1", {31'd0, req1_ready}, 32'd0);
    step();
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    wait_xfer(1);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  task automatic rnd_req(input int n, input int pv);
    logic [31:0] a, b;
    logic        v;
    v = ($urandom_range(99) < pv);
    a = $urandom;
    if ($urandom_range(7) == 0) a = 32'd0;
    b = ($urandom_range(3) == 0) ? a : $urandom;
    set_req(n, v, 4'($urandom_range(15)), a, b);
  endtask

  // A requester only changes its request once the previous one was accepted or it was idle.
  task automatic rand_cycles(input int n, input int pv, input int pr);
    for (int c = 0; c < n; c++) begin
      if (!req0_valid || xfer0) rnd_req(0, pv);
      if (!req1_valid || xfer1) rnd_req(1, pv);
      out_ready = ($urandom_range(99) < pr);
      step();
    end
  endtask

  task automatic idle(input int n);
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    out_ready = 1'b1;
    repeat (n) step();
  endtask

  initial begin
    reset_n   = 1'b1;
    out_ready = 1'b1;
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    step();

    // reset, then first tie to requester 0
    do_reset();
    tie_check();
    idle(2);

    // ADD wraps to zero, result one cycle after acceptance
    set_req(0, 1'b1, 4'd0, 32'hFFFF_FFFF, 32'd1);
    wait_xfer(0);
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    #3;
    chk("add_wrap_valid",   {31'd0, out_valid},   32'd1);
    chk("add_wrap_result",  out_result,           32'd0);
    chk("add_wrap_compare", {31'd0, out_compare}, 32'd0);
    chk("add_wrap_id",      {31'd0, out_id},      32'd0);
    chk("add_wrap_err",     {31'd0, out_err},     32'd0);
    idle(2);

    // both valid every cycle: alternating grants, one result per cycle
    rand_cycles(6, 100, 100);
    idle(3);

    // stall: output held, req1 SUB waits with ready low, then goes through
    out_ready = 1'b0;
    set_req(0, 1'b1, 4'd7, 32'h55, 32'd0);
    wait_xfer(0);
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(1, 1'b1, 4'd1, 32'd5, 32'd7);
    repeat (3) begin
      step();
      chk("stall_req1_ready", {31'd0, req1_ready}, 32'd0);
      chk("stall_held_result", out_result, 32'h55);
    end
    out_ready = 1'b1;
    wait_xfer(1);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    out_ready = 1'b0;
    repeat (3) begin
      step();
      chk("sub_held_result", out_result, 32'hFFFF_FFFE);
      chk("sub_held_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    step();
    idle(2);

    // unsupported opcode
    set_req(1, 1'b1, 4'd10, 32'd9, 32'd9);
    wait_xfer(1);
    set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
    #3;
    chk("badop_result",  out_result,           32'd0);
    chk("badop_err",     {31'd0, out_err},     32'd1);
    chk("badop_compare", {31'd0, out_compare}, 32'd1);
    chk("badop_id",      {31'd0, out_id},      32'd1);
    idle(2);

    // LNOT back to back
    set_req(0, 1'b1, 4'd2, 32'd0, 32'd5);
    wait_xfer(0);
    set_req(0, 1'b1, 4'd2, 32'd3, 32'd5);
    #3;
    chk("lnot_zero_result", out_result, 32'd1);
    step();
    chk("lnot_b2b_xfer", {31'd0, xfer0}, 32'd1);
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    #3;
    chk("lnot_nonzero_result", out_result, 32'd0);
    idle(2);

    // random traffic, reset mid-stream, more random traffic
    rand_cycles(200, 70, 60);
    do_reset();
    tie_check();
    rand_cycles(200, 85, 45);

    idle(4);
    chk("scoreboard_drained", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
